// File: rtl/bus_burst_pkg.sv
// Shared types and widths for the burst responder: FSM state encoding,
// bus field widths and the beat-count width.
package bus_burst_pkg;

  localparam int DATA_W  = 32;
  localparam int BURST_W = 8;
  localparam int BEAT_W  = 9;
  localparam int HS_W    = 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_FETCH = 3'd1,
    READ_BEAT  = 3'd2,
    READ_END   = 3'd3,
    WRITE_BEAT = 3'd4,
    ERROR      = 3'd5
  } state_e;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/sram_sp_32.sv
// Single-port 32-bit SRAM with a registered read port (one-cycle latency).
// The read register holds its value whenever no read is issued.
module sram_sp_32
  import bus_burst_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_burst_responder.sv
// Burst bus target exposing a word-addressed SRAM window. Reads prefetch the
// next word while the current beat is on the bus so unstalled beats are back to back.
module bus_burst_responder
  import bus_burst_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h5000_0000,
  parameter int          SIZE_WORDS     = 512,
  parameter bit          WRITE_THROTTLE = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  busIn_address_data,
  input  logic [HS_W-1:0]    busIn_begin_transaction,
  input  logic [HS_W-1:0]    busIn_end_transaction,
  input  logic [HS_W-1:0]    busIn_data_valid,
  input  logic [HS_W-1:0]    busIn_read_n_write,
  input  logic [HS_W-1:0]    busIn_busy,
  input  logic [BURST_W-1:0] busIn_burst_size,
  output logic [DATA_W-1:0]  busOut_address_data,
  output logic [HS_W-1:0]    busOut_data_valid,
  output logic [HS_W-1:0]    busOut_end_transaction,
  output logic [HS_W-1:0]    busOut_busy,
  output logic [HS_W-1:0]    busOut_error
);

  localparam int          AW        = $clog2(SIZE_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(SIZE_WORDS) * 33'd4;
  localparam logic [AW:0] IDX_END   = (AW+1)'(SIZE_WORDS);

  state_e            state_q, state_d;
  logic [AW:0]       idx_q, idx_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] wcnt_q, wcnt_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] offset_s;
  logic              hit_s;
  logic [AW:0]       start_idx_s;
  logic [AW:0]       next_idx_s;
  logic              ram_en_s, ram_we_s;
  logic [AW-1:0]     ram_addr_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign offset_s    = busIn_address_data - BASE_ADDRESS;
  assign hit_s       = busIn_begin_transaction && (busIn_address_data >= BASE_ADDRESS)
                       && ({1'b0, offset_s} < WIN_BYTES);
  assign start_idx_s = {1'b0, offset_s[AW+1:2]};
  assign next_idx_s  = idx_q + (AW+1)'(1);

  // idx_q is the word on the bus (reads) or the next word to write (writes);
  // beats_q counts remaining read beats or holds the announced write length.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    beats_d    = beats_q;
    wcnt_d     = wcnt_q;
    busy_d     = 1'b0;
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = idx_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          idx_d   = start_idx_s;
          beats_d = BEAT_W'(busIn_burst_size) + BEAT_W'(1);
          wcnt_d  = '0;
          if (!word_aligned(busIn_address_data[1:0])) begin
            state_d = ERROR;
          end else if (busIn_read_n_write) begin
            state_d = READ_FETCH;
          end else begin
            state_d = WRITE_BEAT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ_FETCH: begin
        if (busIn_end_transaction) begin
          state_d = IDLE;
        end else begin
          ram_en_s = 1'b1;
          state_d  = READ_BEAT;
        end
      end
      READ_BEAT: begin
        if (busIn_end_transaction) begin
          state_d = IDLE;
        end else if (!busIn_busy) begin
          if (beats_q == BEAT_W'(1)) begin
            state_d = READ_END;
          end else if (next_idx_s == IDX_END) begin
            state_d = ERROR;
          end else begin
            ram_en_s   = 1'b1;
            ram_addr_s = next_idx_s[AW-1:0];
            idx_d      = next_idx_s;
            beats_d    = beats_q - BEAT_W'(1);
          end
        end else begin
          state_d = READ_BEAT;
        end
      end
      WRITE_BEAT: begin
        if (busIn_data_valid && !busy_q) begin
          if ((wcnt_q == beats_q) || (idx_q == IDX_END)) begin
            state_d = ERROR;
          end else begin
            ram_en_s = 1'b1;
            ram_we_s = 1'b1;
            idx_d    = next_idx_s;
            wcnt_d   = wcnt_q + BEAT_W'(1);
            if (busIn_end_transaction) begin
              state_d = IDLE;
            end else begin
              busy_d = WRITE_THROTTLE && (wcnt_d[1:0] == 2'b00);
            end
          end
        end else if (busIn_end_transaction) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE_BEAT;
        end
      end
      READ_END: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beats_q <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
    end
  end

  sram_sp_32 #(
    .DEPTH (SIZE_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .en_i    (ram_en_s & ~reset),
    .we_i    (ram_we_s & ~reset),
    .addr_i  (ram_addr_s),
    .wdata_i (busIn_address_data),
    .rdata_o (ram_rdata_s)
  );

  // Outputs decode registered state only; idle states drive zeros for the wired-OR bus.
  assign busOut_data_valid      = (state_q == READ_BEAT);
  assign busOut_address_data    = busOut_data_valid ? ram_rdata_s : 32'h0000_0000;
  assign busOut_end_transaction = (state_q == READ_END) || (state_q == ERROR);
  assign busOut_error           = (state_q == ERROR);
  assign busOut_busy            = busy_q;

endmodule

// File: tb/tb_bus_burst_responder.sv
// Directed bench for bus_burst_responder: a plain and a write-throttled instance,
// bench-side memory models and a read-data queue checked as beats appear.
module tb_bus_burst_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          SZ   = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_ad;
  logic        in_begin, in_end, in_dv, in_rnw, in_busy;
  logic [7:0]  in_burst;

  logic [31:0] d0_data, d1_data;
  logic        d0_valid, d0_end, d0_busy, d0_err;
  logic        d1_valid, d1_end, d1_busy, d1_err;

  logic [31:0] mdl0 [SZ];
  logic [31:0] mdl1 [SZ];
  logic [31:0] exp_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_burst_responder #(.BASE_ADDRESS(BASE), .SIZE_WORDS(SZ), .WRITE_THROTTLE(1'b0)) dut0 (
    .clock(clk), .reset(reset), .busIn_address_data(in_ad),
    .busIn_begin_transaction(in_begin), .busIn_end_transaction(in_end),
    .busIn_data_valid(in_dv), .busIn_read_n_write(in_rnw), .busIn_busy(in_busy),
    .busIn_burst_size(in_burst), .busOut_address_data(d0_data),
    .busOut_data_valid(d0_valid), .busOut_end_transaction(d0_end),
    .busOut_busy(d0_busy), .busOut_error(d0_err));

  bus_burst_responder #(.BASE_ADDRESS(BASE), .SIZE_WORDS(SZ), .WRITE_THROTTLE(1'b1)) dut1 (
    .clock(clk), .reset(reset), .busIn_address_data(in_ad),
    .busIn_begin_transaction(in_begin), .busIn_end_transaction(in_end),
    .busIn_data_valid(in_dv), .busIn_read_n_write(in_rnw), .busIn_busy(in_busy),
    .busIn_burst_size(in_burst), .busOut_address_data(d1_data),
    .busOut_data_valid(d1_valid), .busOut_end_transaction(d1_end),
    .busOut_busy(d1_busy), .busOut_error(d1_err));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input bit sel, output logic [31:0] d, output logic v,
                         output logic e, output logic b, output logic er);
    d  = sel ? d1_data  : d0_data;
    v  = sel ? d1_valid : d0_valid;
    e  = sel ? d1_end   : d0_end;
    b  = sel ? d1_busy  : d0_busy;
    er = sel ? d1_err   : d0_err;
  endtask

  task automatic chk_idle(input string tag, input bit sel);
    logic [31:0] d;
    logic v, e, b, er;
    get_obs(sel, d, v, e, b, er);
    chk({tag, "_data"},  d, 32'h0);
    chk({tag, "_valid"}, {31'b0, v}, 32'd0);
    chk({tag, "_end"},   {31'b0, e}, 32'd0);
    chk({tag, "_busy"},  {31'b0, b}, 32'd0);
    chk({tag, "_err"},   {31'b0, er}, 32'd0);
  endtask

  task automatic begin_txn(input logic [31:0] addr, input logic rnw, input logic [7:0] burst);
    in_begin = 1'b1; in_ad = addr; in_rnw = rnw; in_burst = burst;
    step();
    in_begin = 1'b0; in_ad = 32'h0;
  endtask

  // Sends nsend beats with data_valid held high; a beat shown while busy is re-sent.
  task automatic write_burst(input string tag, input bit sel, input logic [31:0] addr,
                             input int burst, input int nsend, input logic [31:0] first);
    int idx = int'((addr - BASE) >> 2);
    int sent = 0;
    bit last4 = 1'b0;
    logic [31:0] d;
    logic v, e, b, er;
    begin_txn(addr, 1'b0, 8'(burst));
    while (sent < nsend) begin
      get_obs(sel, d, v, e, b, er);
      chk({tag, "_busy"}, {31'b0, b}, {31'b0, sel & last4});
      chk({tag, "_end"},  {31'b0, e}, 32'd0);
      in_dv = 1'b1;
      in_ad = first + 32'(sent);
      if (!b) begin
        if (sent < burst + 1) begin
          if (sel) mdl1[idx + sent] = in_ad; else mdl0[idx + sent] = in_ad;
        end
        sent++;
        last4 = ((sent % 4) == 0);
      end else begin
        last4 = 1'b0;
      end
      step();
    end
    get_obs(sel, d, v, e, b, er);
    if (nsend > burst + 1) begin
      chk({tag, "_ovf_err"}, {31'b0, er}, 32'd1);
      chk({tag, "_ovf_end"}, {31'b0, e},  32'd1);
      in_dv = 1'b0;
      step();
    end else begin
      chk({tag, "_busy_last"}, {31'b0, b}, {31'b0, sel & last4});
      in_dv = 1'b0; in_end = 1'b1; in_ad = 32'h0;
      step();
      in_end = 1'b0;
    end
    chk_idle({tag, "_after"}, sel);
  endtask

  // Stalls beats sa and sb for slen cycles each; expects nvalid beats then end/error.
  task automatic read_burst(input string tag, input bit sel, input logic [31:0] addr,
                            input int burst, input int nvalid, input int sa, input int sb,
                            input int slen, input int exp_vcyc, input bit exp_err);
    int idx = int'((addr - BASE) >> 2);
    int cyc = 1, beats = 0, vcyc = 0, scnt = 0, first_v = -1, last_v = -1;
    bit done = 1'b0;
    bit bz;
    logic [31:0] d;
    logic v, e, b, er;
    for (int i = 0; i < nvalid; i++) exp_q.push_back(sel ? mdl1[idx + i] : mdl0[idx + i]);
    begin_txn(addr, 1'b1, 8'(burst));
    while (!done && cyc < 60) begin
      get_obs(sel, d, v, e, b, er);
      bz = v && ((beats + 1 == sa) || (beats + 1 == sb)) && (scnt < slen);
      if (v) begin
        if (first_v < 0) first_v = cyc;
        vcyc++;
        if (exp_q.size() > 0) chk({tag, "_data"}, d, exp_q[0]);
        else chk({tag, "_extra_beat"}, {31'b0, v}, 32'd0);
        if (!bz) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats++; last_v = cyc; scnt = 0;
        end else begin
          scnt++;
        end
      end
      if (e) begin
        chk({tag, "_err"},      {31'b0, er}, {31'b0, exp_err});
        chk({tag, "_end_gap"},  32'(cyc), 32'(last_v + 1));
        done = 1'b1;
      end
      in_busy = bz;
      step();
      cyc++;
    end
    in_busy = 1'b0;
    chk({tag, "_done"},      {31'b0, done}, 32'd1);
    chk({tag, "_first_lat"}, 32'(first_v), 32'd2);
    chk({tag, "_beats"},     32'(beats), 32'(nvalid));
    chk({tag, "_vcycles"},   32'(vcyc), 32'(exp_vcyc));
    chk({tag, "_qleft"},     32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk_idle({tag, "_after"}, sel);
  endtask

  initial begin
    reset = 1'b1; in_ad = 32'h0; in_begin = 1'b0; in_end = 1'b0; in_dv = 1'b0;
    in_rnw = 1'b0; in_busy = 1'b0; in_burst = 8'h0;
    repeat (3) step();
    chk_idle("reset0", 1'b0);
    chk_idle("reset1", 1'b1);
    reset = 1'b0;
    step();
    chk_idle("post_reset", 1'b0);

    write_burst("wr_a", 1'b0, BASE + 32'h10, 3, 4, 32'd1);
    step();
    read_burst("rd_a", 1'b0, BASE + 32'h10, 3, 4, 0, 0, 0, 4, 1'b0);
    step();

    write_burst("wr_b", 1'b0, BASE + 32'h20, 3, 4, 32'd5);
    step();
    read_burst("rd_stall", 1'b0, BASE + 32'h10, 7, 8, 2, 5, 2, 12, 1'b0);
    step();

    write_burst("wr_w0", 1'b0, BASE, 0, 1, 32'hA5A5_0000);
    step();
    begin_txn(BASE + 32'h2, 1'b0, 8'd0);
    chk("misalign_err",   {31'b0, d0_err},   32'd1);
    chk("misalign_end",   {31'b0, d0_end},   32'd1);
    chk("misalign_valid", {31'b0, d0_valid}, 32'd0);
    in_dv = 1'b1; in_ad = 32'hDEAD_BEEF;
    step();
    in_dv = 1'b0; in_ad = 32'h0;
    chk_idle("misalign_after", 1'b0);
    step();
    read_burst("rd_w0", 1'b0, BASE, 0, 1, 0, 0, 0, 1, 1'b0);

    begin_txn(BASE - 32'h4, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      chk_idle("miss", 1'b0);
      step();
    end

    write_burst("wr_pre", 1'b0, BASE + 32'h48, 0, 1, 32'h55);
    step();
    write_burst("wr_extra", 1'b0, BASE + 32'h40, 1, 3, 32'h100);
    step();
    read_burst("rd_extra", 1'b0, BASE + 32'h40, 2, 3, 0, 0, 0, 3, 1'b0);
    step();

    write_burst("wr_top", 1'b0, BASE + 32'(4 * (SZ - 2)), 1, 2, 32'h1F0);
    step();
    read_burst("rd_ovr", 1'b0, BASE + 32'(4 * (SZ - 2)), 3, 2, 0, 0, 0, 2, 1'b1);
    step(); step();

    write_burst("wr_thr", 1'b1, BASE + 32'h100, 7, 8, 32'h800);
    step(); step();
    read_burst("rd_thr", 1'b1, BASE + 32'h100, 7, 8, 0, 0, 0, 8, 1'b0);
    step(); step();

    begin_txn(BASE + 32'h10, 1'b1, 8'd7);
    step();
    repeat (2) step();
    chk("rst_beat3_valid", {31'b0, d0_valid}, 32'd1);
    chk("rst_beat3_data",  d0_data, mdl0[6]);
    reset = 1'b1;
    step();
    chk_idle("rst_mid", 1'b0);
    reset = 1'b0;
    step();
    chk_idle("rst_mid_after", 1'b0);
    read_burst("rd_after_rst", 1'b0, BASE + 32'h10, 7, 8, 0, 0, 0, 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
